// File: rtl/inst_rom_loader.sv
// inst_rom_loader
// ----------------
// Instruction memory for the single-cycle MIPS core. After reset it fills
// itself from a byte-serial boot stream: a 2-byte big-endian word count N,
// then N 32-bit words, each sent MSB byte first. Until the load completes,
// the core is held in reset and fetches read as zero.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   rst         synchronous active-high reset (memory contents are kept)
//   ce_i        fetch chip-enable from the core
//   addr_i      fetch byte address; bits [1:0] and bits above the depth are ignored
//   inst_o      fetched instruction, combinational; zero unless ce_i && ld_done_o
//   ld_valid_i  boot-stream byte valid
//   ld_data_i   boot-stream byte
//   ld_ready_o  loader accepts a byte (every state except done)
//   ld_done_o   load complete, memory visible to the core
//   ld_ovf_o    sticky: header count exceeded memory depth
//   core_rst_o  core reset, high until the load completes
module inst_rom_loader #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LEN_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] addr_i,
    output logic [31:0] inst_o,
    input  logic        ld_valid_i,
    input  logic [7:0]  ld_data_i,
    output logic        ld_ready_o,
    output logic        ld_done_o,
    output logic        ld_ovf_o,
    output logic        core_rst_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Depth widened by one bit so that counts/pointers can be compared
    // against it without overflowing when DEPTH == 2**LEN_W.
    localparam logic [LEN_W:0] DEPTH_X = (LEN_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [7:0]       len_hi_q;
    logic [LEN_W-1:0] wptr_q;
    logic [LEN_W-1:0] remaining_q;
    logic [1:0]       byte_idx_q;
    logic [23:0]      asm_q;
    logic             done_q;
    logic             ovf_q;

    logic [31:0] mem [DEPTH];

    logic             xfer;
    logic [LEN_W-1:0] len_w;
    logic             mem_we;

    assign xfer  = ld_valid_i & ld_ready_o;
    assign len_w = LEN_W'({len_hi_q, ld_data_i});

    // Words beyond the array are consumed but never written: no wrap into
    // low memory. Reset drops a byte that arrives on the same edge.
    assign mem_we = xfer && !rst && (state_q == S_DATA) && (byte_idx_q == 2'd3)
                    && ({1'b0, wptr_q} < DEPTH_X);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr_q[DEPTH_LOG2-1:0]] <= {asm_q, ld_data_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LEN_HI;
            len_hi_q    <= 8'h00;
            wptr_q      <= '0;
            remaining_q <= '0;
            byte_idx_q  <= 2'd0;
            asm_q       <= 24'h0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (xfer) begin
            case (state_q)
                S_LEN_HI: begin
                    len_hi_q <= ld_data_i;
                    state_q  <= S_LEN_LO;
                end
                S_LEN_LO: begin
                    if ({1'b0, len_w} > DEPTH_X) begin
                        ovf_q <= 1'b1;
                    end
                    if (len_w == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q     <= S_DATA;
                        remaining_q <= len_w;
                        byte_idx_q  <= 2'd0;
                    end
                end
                S_DATA: begin
                    asm_q      <= {asm_q[15:0], ld_data_i};
                    byte_idx_q <= byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        wptr_q      <= wptr_q + LEN_W'(1);
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    // S_DONE is terminal; xfer cannot occur here anyway.
                end
            endcase
        end
    end

    assign ld_ready_o = (state_q != S_DONE);
    assign ld_done_o  = done_q;
    assign ld_ovf_o   = ovf_q;
    assign core_rst_o = ~done_q;

    // Reads alias modulo depth; gated to zero until the image is complete.
    assign inst_o = (ce_i && done_q) ? mem[addr_i[DEPTH_LOG2+1:2]] : 32'h0;

    logic unused_addr;
    assign unused_addr = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};

endmodule

// File: tb/tb_inst_rom_loader.sv
// Two loaders (depth 1024 and depth 4) receive the identical stimulus.
// The driver updates a byte-stream reference model on each issued cycle and
// queues the expected outputs; a monitor pops and compares after each edge.
module tb_inst_rom_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic        ld_valid_i = 1'b0;
    logic [7:0]  ld_data_i = 8'h0;

    logic [31:0] inst_w [2];
    logic [1:0]  ready_w, done_w, ovf_w, crst_w;

    always #5 clk = ~clk;

    inst_rom_loader #(.DEPTH_LOG2(10), .LEN_W(16)) dut_big (
        .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i), .inst_o(inst_w[0]),
        .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i), .ld_ready_o(ready_w[0]),
        .ld_done_o(done_w[0]), .ld_ovf_o(ovf_w[0]), .core_rst_o(crst_w[0])
    );

    inst_rom_loader #(.DEPTH_LOG2(2), .LEN_W(16)) dut_small (
        .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i), .inst_o(inst_w[1]),
        .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i), .ld_ready_o(ready_w[1]),
        .ld_done_o(done_w[1]), .ld_ovf_o(ovf_w[1]), .core_rst_o(crst_w[1])
    );

    // ---------------- reference model ----------------
    int          dep [2] = '{1024, 4};
    logic [7:0]  acc [$];          // bytes accepted since the last reset
    bit          m_done = 1'b0;
    logic [31:0] mmem   [2][1024]; // persists across reset, like the array
    bit          mknown [2][1024];

    typedef struct packed {
        logic        ready;
        logic        done;
        logic [1:0]  ovf;
        logic [1:0]  known;
        logic [31:0] inst1;
        logic [31:0] inst0;
    } exp_t;

    exp_t exp_q [$];
    int   total = 0;
    int   bad   = 0;

    function automatic int hdr_n();
        return (acc.size() >= 2) ? int'({acc[0], acc[1]}) : -1;
    endfunction

    task automatic model_edge(input bit r, input bit v, input logic [7:0] d);
        int sz, n, wi;
        if (r) begin
            acc.delete();
            m_done = 1'b0;
        end else if (v && !m_done) begin
            acc.push_back(d);
            sz = acc.size();
            n  = hdr_n();
            if (sz > 2 && (sz - 2) % 4 == 0) begin
                wi = (sz - 2) / 4 - 1;
                for (int k = 0; k < 2; k++) begin
                    if (wi < dep[k]) begin
                        mmem[k][wi]   = {acc[sz-4], acc[sz-3], acc[sz-2], acc[sz-1]};
                        mknown[k][wi] = 1'b1;
                    end
                end
            end
            if (n >= 0 && sz == 2 + 4 * n) m_done = 1'b1;
        end
    endtask

    // One cycle of stimulus: drive at negedge, model the coming edge, queue expectations.
    task automatic step(input bit r, input bit v, input logic [7:0] d,
                        input bit ce, input logic [31:0] a);
        exp_t e;
        int   idx;
        logic [31:0] iv [2];
        @(negedge clk);
        rst = r; ld_valid_i = v; ld_data_i = d; ce_i = ce; addr_i = a;
        model_edge(r, v, d);
        e.ready = !m_done;
        e.done  = m_done;
        for (int k = 0; k < 2; k++) begin
            e.ovf[k]   = (hdr_n() > dep[k]);
            e.known[k] = 1'b1;
            iv[k]      = 32'h0;
            if (ce && m_done) begin
                idx        = int'(a >> 2) % dep[k];
                e.known[k] = mknown[k][idx];
                iv[k]      = mmem[k][idx];
            end
        end
        e.inst0 = iv[0];
        e.inst1 = iv[1];
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("ready[%0d]", k),    32'(ready_w[k]), 32'(e.ready));
                chk($sformatf("done[%0d]", k),     32'(done_w[k]),  32'(e.done));
                chk($sformatf("core_rst[%0d]", k), 32'(crst_w[k]),  32'(!e.done));
                chk($sformatf("ovf[%0d]", k),      32'(ovf_w[k]),   32'(e.ovf[k]));
                if (e.known[k])
                    chk($sformatf("inst[%0d] addr=%h ce=%0d", k, addr_i, ce_i),
                        inst_w[k], (k == 0) ? e.inst0 : e.inst1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] sb [$];

    task automatic build(input int n, input bit rnd, input logic [31:0] base);
        logic [31:0] w;
        sb.delete();
        sb.push_back(8'(n >> 8));
        sb.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            w = rnd ? $urandom : base * 32'(i + 1);
            for (int b = 3; b >= 0; b--) sb.push_back(w[b*8 +: 8]);
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'($urandom % 2), 8'($urandom), 1'b1, $urandom);
    endtask

    // Sends sb; vpct = % of cycles with valid; a reset is issued once when
    // rst_after bytes have gone out, after which the stream starts over.
    task automatic send(input int vpct, input int rst_after);
        int i = 0;
        bit did_rst = 1'b0;
        bit v;
        while (i < sb.size()) begin
            if (!did_rst && i == rst_after) begin
                do_reset();
                did_rst = 1'b1;
                i = 0;
            end else begin
                v = (int'($urandom % 100) < vpct);
                step(1'b0, v, v ? sb[i] : 8'($urandom), 1'($urandom % 2), $urandom);
                if (v) i++;
            end
        end
    endtask

    task automatic reads(input int n);
        logic [31:0] a;
        int lim = (n < 12) ? n : 12;
        for (int j = 0; j < lim + 4; j++) begin
            a = $urandom;
            if (j < lim) a[11:2] = 10'(j);
            step(1'b0, 1'($urandom % 2), 8'($urandom), ($urandom % 4) != 0, a);
        end
    endtask

    task automatic report(input string nm);
        $display("load %s: bytes=%0d done=%0d big_ovf=%0d small_ovf=%0d", nm,
                 acc.size(), m_done, ovf_w[0], ovf_w[1]);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n, ra;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 1024; i++) mknown[k][i] = 1'b0;

        // Directed stream: 00 03 | 34011100 | 34020020 | 00000000
        do_reset();
        sb = '{8'h00, 8'h03, 8'h34, 8'h01, 8'h11, 8'h00,
               8'h34, 8'h02, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
        send(100, -1);
        step(1'b0, 1'b0, 8'h0, 1'b1, 32'h4);
        step(1'b0, 1'b0, 8'h0, 1'b1, 32'h6);
        step(1'b0, 1'b0, 8'h0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 8'hAA, 1'b1, 32'h0);
        report("directed");

        // Same stream with valid toggling.
        do_reset();
        for (int i = 0; i < sb.size(); i++) begin
            step(1'b0, 1'b1, sb[i], 1'b1, $urandom);
            step(1'b0, 1'b0, 8'hFF, 1'b1, $urandom);
        end
        reads(3);
        report("toggled");

        // Empty image; trailing bytes ignored.
        do_reset();
        sb = '{8'h00, 8'h00, 8'h12, 8'h34, 8'h56};
        send(100, -1);
        reads(1);
        report("empty");

        // N=5: overflows the depth-4 instance.
        do_reset();
        build(5, 1'b0, 32'h11111111);
        send(100, -1);
        step(1'b0, 1'b0, 8'h0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 8'h0, 1'b1, 32'h10);
        reads(5);
        report("n5");

        // Reset after 7 bytes, then the full stream.
        do_reset();
        sb = '{8'h00, 8'h03, 8'h34, 8'h01, 8'h11, 8'h00,
               8'h34, 8'h02, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
        send(100, 7);
        reads(3);
        report("restart");

        // Random images, random valid density, occasional mid-load reset.
        for (int t = 0; t < 12; t++) begin
            n  = 1 + int'($urandom % 8);
            ra = ($urandom % 3 == 0) ? int'($urandom % (2 + 4 * n)) : -1;
            do_reset();
            build(n, 1'b1, 32'h0);
            send(30 + int'($urandom % 71), ra);
            reads(n);
            report($sformatf("rand%0d", t));
        end

        // Count beyond the big array: discarded tail, ovf on both.
        do_reset();
        build(1030, 1'b1, 32'h0);
        send(100, -1);
        reads(12);
        step(1'b0, 1'b0, 8'h0, 1'b1, 32'h0);
        report("n1030");

        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
